move_entry: RTL and testbench

- Upstream input stage for the game FSM (myExplicitFSM).
- Converts the raw 4-bit switch value and a raw Enter button into a clean, registered, one-cycle human move on hMove. hMove idles at 4'hF.
- Rejects illegal moves: value outside 1..9, square already taken by either player, or game already won.
- Keeps a 9-bit occupancy record. Human squares come from accepted moves; computer squares come from watching the FSM's cMove output.

---
 rtl/game_pkg.sv | 27 ++
 rtl/sync_chain.sv | 32 +++
 rtl/move_entry.sv | 154 +++++++++++++++
 tb/tb_move_entry.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module   : game_pkg
// Brief    : Shared move type, entry-stage state encoding and square check
//            for the tic-tac-toe move entry path.
// Revision : 1.0 - initial release
// ============================================================================
package game_pkg;

    // Value presented on a move bus when no move is being offered.
    localparam logic [3:0] IDLE_MOVE_C = 4'hF;

    typedef logic [3:0] move_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_REL = 2'd2
    } entry_state_t;

    // True when the value names a board square (1..9).
    function automatic logic legal_sq(input move_t m);
        return (m >= 4'd1) && (m <= 4'd9);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_chain.sv
`default_nettype none
// ============================================================================
// Module   : sync_chain
// Brief    : STAGES-deep flop chain bringing an asynchronous bus into the
//            clock domain; all stages clear to zero on reset.
// Revision : 1.0 - initial release
// ============================================================================
module sync_chain #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout
);

    logic [STAGES-1:0][WIDTH-1:0] r_stage;

    // Shift the raw input one stage deeper every clock.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_stage <= '0;
        end else begin
            r_stage <= {r_stage[STAGES-2:0], i_din};
        end
    end

    assign o_dout = r_stage[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/move_entry.sv
`default_nettype none
// ============================================================================
// Module   : move_entry
// Brief    : Turns the raw switch value and Enter button into a single-cycle
//            registered human move, rejecting illegal presses and tracking
//            board occupancy from both players.
// Revision : 1.0 - initial release
// ============================================================================
module move_entry
    import game_pkg::*;
#(
    parameter int          SYNC_STAGES = 2,
    parameter logic [3:0]  IDLE_MOVE   = IDLE_MOVE_C
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] sw,
    input  logic       enter,
    input  logic       new_game,
    input  logic [3:0] cMove,
    input  logic       win,
    output logic [3:0] hMove,
    output logic       move_pulse,
    output logic       err,
    output logic [8:0] occupied,
    output logic       busy
);

    localparam logic [2:0] c_settle_max = 3'(SYNC_STAGES);

    move_t        w_sw_s;
    logic         w_enter_s;
    logic         r_enter_d;
    logic [2:0]   r_settle;
    entry_state_t r_state;
    logic         r_game_over;
    move_t        r_last_cmove;

    logic         w_press;
    logic         w_cm_new;
    logic [8:0]   w_cm_mask;
    logic [8:0]   w_hm_mask;
    logic         w_legal;
    logic         w_take;

    sync_chain #(.WIDTH(4), .STAGES(SYNC_STAGES)) u_sync_sw (
        .clock  (clock),
        .reset  (reset),
        .i_din  (sw),
        .o_dout (w_sw_s)
    );

    sync_chain #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_enter (
        .clock  (clock),
        .reset  (reset),
        .i_din  (enter),
        .o_dout (w_enter_s)
    );

    // The first synchronised Enter sample after reset is taken as the button's
    // previous level, so a button held through reset never reads as a press.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_settle  <= 3'd0;
            r_enter_d <= 1'b1;
        end else if (r_settle != c_settle_max) begin
            r_settle  <= r_settle + 3'd1;
            r_enter_d <= 1'b1;
        end else begin
            r_enter_d <= w_enter_s;
        end
    end

    assign w_press   = w_enter_s & ~r_enter_d;
    assign w_cm_new  = legal_sq(cMove) && (cMove != r_last_cmove);
    assign w_cm_mask = w_cm_new ? (9'd1 << (cMove - 4'd1)) : 9'd0;
    assign w_hm_mask = legal_sq(w_sw_s) ? (9'd1 << (w_sw_s - 4'd1)) : 9'd0;

    // A computer capture of the same square in this cycle wins the square.
    assign w_legal   = legal_sq(w_sw_s)
                    && ((occupied & w_hm_mask) == 9'd0)
                    && !r_game_over
                    && !(w_cm_new && (cMove == w_sw_s));
    assign w_take    = (r_state == IDLE) && w_press && w_legal;

    // Entry FSM with registered outputs, occupancy and game-over tracking.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_game_over  <= 1'b0;
            r_last_cmove <= 4'd0;
            hMove        <= IDLE_MOVE;
            move_pulse   <= 1'b0;
            err          <= 1'b0;
            occupied     <= 9'd0;
            busy         <= 1'b0;
        end else if (new_game) begin
            r_game_over  <= 1'b0;
            r_last_cmove <= 4'd0;
            occupied     <= 9'd0;
            hMove        <= IDLE_MOVE;
            move_pulse   <= 1'b0;
            err          <= 1'b0;
            r_state      <= w_enter_s ? WAIT_REL : IDLE;
            busy         <= w_enter_s;
        end else begin
            hMove      <= IDLE_MOVE;
            move_pulse <= 1'b0;
            err        <= 1'b0;
            occupied   <= occupied | w_cm_mask | (w_take ? w_hm_mask : 9'd0);
            if (w_cm_new) begin
                r_last_cmove <= cMove;
            end
            if (win) begin
                r_game_over <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_press) begin
                        busy <= 1'b1;
                        if (w_legal) begin
                            hMove      <= w_sw_s;
                            move_pulse <= 1'b1;
                            r_state    <= ISSUE;
                        end else begin
                            err     <= 1'b1;
                            r_state <= WAIT_REL;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ISSUE: begin
                    r_state <= WAIT_REL;
                    busy    <= 1'b1;
                end
                WAIT_REL: begin
                    if (!w_enter_s) begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                    end else begin
                        busy <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_move_entry.sv
`default_nettype none
// ============================================================================
// Module   : tb_move_entry
// Brief    : Self-checking bench for move_entry: directed scenarios with
//            literal expectations plus randomized traffic against a
//            behavioural model of the entry rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_move_entry;

    localparam int S = 2;

    logic       clock    = 1'b0;
    logic       reset    = 1'b0;
    logic [3:0] sw       = 4'd0;
    logic       enter    = 1'b0;
    logic       new_game = 1'b0;
    logic [3:0] cMove    = 4'hF;
    logic       win      = 1'b0;
    logic [3:0] hMove;
    logic       move_pulse;
    logic       err;
    logic [8:0] occupied;
    logic       busy;

    move_entry #(.SYNC_STAGES(S), .IDLE_MOVE(4'hF)) dut (
        .clock      (clock),
        .reset      (reset),
        .sw         (sw),
        .enter      (enter),
        .new_game   (new_game),
        .cMove      (cMove),
        .win        (win),
        .hMove      (hMove),
        .move_pulse (move_pulse),
        .err        (err),
        .occupied   (occupied),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    int         errors = 0;
    int         checks = 0;
    int         pulses = 0;
    int         errs   = 0;
    logic [3:0] last_h = 4'hF;
    int         p0;
    int         e0;

    // Model: raw input history since reset and the game as the rules describe it.
    bit         q_en[$];
    logic [3:0] q_sw[$];
    logic [3:0] m_h;
    bit         m_p, m_e, m_b;
    logic [8:0] m_occ;
    bit         m_go;
    logic [3:0] m_last;
    bit         m_issued;   // a move went out on the previous edge
    bit         m_await;    // press consumed, waiting for Enter to be let go

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q_en.delete();
        q_sw.delete();
        m_h = 4'hF; m_p = 0; m_e = 0; m_b = 0;
        m_occ = 9'd0; m_go = 0; m_last = 4'd0;
        m_issued = 0; m_await = 0;
    endtask

    task automatic model_step();
        int         n;
        bit         es, pr, cm_new, take;
        logic [3:0] ssw;
        q_en.push_back(enter);
        q_sw.push_back(sw);
        n   = q_en.size();
        // Enter/sw as seen S edges late; the first post-reset sample has no
        // predecessor, so it can never form a rising edge.
        es  = (n >= S + 1) ? q_en[n-1-S] : 1'b0;
        ssw = (n >= S + 1) ? q_sw[n-1-S] : 4'd0;
        pr  = (n >= S + 2) && q_en[n-1-S] && !q_en[n-2-S];
        cm_new = (cMove >= 4'd1) && (cMove <= 4'd9) && (cMove != m_last);
        m_h = 4'hF; m_p = 0; m_e = 0; take = 0;
        if (new_game) begin
            m_occ = 9'd0; m_go = 0; m_last = 4'd0;
            m_issued = 0; m_await = es; m_b = es;
        end else begin
            if (m_issued) begin
                m_issued = 0; m_await = 1;
            end else if (m_await) begin
                m_await = es;
            end else if (pr) begin
                if (ssw >= 4'd1 && ssw <= 4'd9 && !m_occ[ssw-4'd1] && !m_go
                    && !(cm_new && cMove == ssw)) begin
                    m_h = ssw; m_p = 1; m_issued = 1; take = 1;
                end else begin
                    m_e = 1; m_await = 1;
                end
            end
            if (cm_new) begin
                m_occ[cMove-4'd1] = 1'b1;
                m_last = cMove;
            end
            if (take) m_occ[ssw-4'd1] = 1'b1;
            if (win) m_go = 1;
            m_b = m_issued || m_await;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clock or negedge reset);
            if (!reset) model_reset();
            else model_step();
        end
    end

    // Compare every output against the model once per cycle.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset) begin
                chk("rst_hMove", hMove, 4'hF);
                chk("rst_occupied", occupied, 9'd0);
                chk("rst_flags", {move_pulse, err, busy}, 3'b000);
            end else begin
                chk("hMove", hMove, m_h);
                chk("move_pulse", move_pulse, m_p);
                chk("err", err, m_e);
                chk("occupied", occupied, m_occ);
                chk("busy", busy, m_b);
                if (move_pulse) begin pulses++; last_h = hMove; end
                if (err) errs++;
            end
        end
    end

    task automatic settle(input int n);
        repeat (n) @(negedge clock);
        #1;
    endtask

    task automatic press(input logic [3:0] v, input int hold);
        @(negedge clock);
        sw = v; enter = 1'b1;
        repeat (hold) @(negedge clock);
        enter = 1'b0;
        settle(6);
    endtask

    task automatic pulse_new_game();
        @(negedge clock); new_game = 1'b1;
        @(negedge clock); new_game = 1'b0;
        settle(1);
    endtask

    initial begin
        settle(3);
        reset = 1'b1;
        settle(5);

        // Scenario 1: single move, exact latency, busy until release settles.
        sw = 4'd6; enter = 1'b1;
        @(posedge clock); @(posedge clock); #1;
        chk("s1_before_issue", hMove, 4'hF);
        @(posedge clock); #1;
        chk("s1_issue_hMove", hMove, 4'd6);
        chk("s1_issue_pulse", move_pulse, 1'b1);
        @(posedge clock); #1;
        chk("s1_after_issue", {hMove, move_pulse}, {4'hF, 1'b0});
        repeat (7) @(negedge clock);
        enter = 1'b0;
        @(posedge clock); @(posedge clock); #1;
        chk("s1_busy_held", busy, 1'b1);
        @(posedge clock); #1;
        chk("s1_busy_drop", busy, 1'b0);
        settle(4);
        chk("s1_occupied", occupied, 9'h020);
        chk("s1_pulses", pulses, 1);

        // Scenario 2: computer takes 9, human retry on 9 rejected, 2 accepted.
        @(negedge clock); cMove = 4'd9;
        @(negedge clock); cMove = 4'hF;
        settle(1);
        chk("s2_cmove_occ", occupied, 9'h120);
        e0 = errs; p0 = pulses;
        press(4'd9, 4);
        chk("s2_taken_err", errs, e0 + 1);
        chk("s2_taken_nopulse", pulses, p0);
        press(4'd2, 4);
        chk("s2_move2", last_h, 4'd2);
        chk("s2_occupied", occupied, 9'h122);

        // Scenario 3: out-of-range values.
        e0 = errs;
        press(4'd0, 3);
        press(4'hA, 3);
        chk("s3_errs", errs, e0 + 2);
        chk("s3_occupied", occupied, 9'h122);

        // Scenario 4: sw changes while Enter is held.
        pulse_new_game();
        chk("s4_cleared", occupied, 9'd0);
        p0 = pulses;
        @(negedge clock); sw = 4'd6; enter = 1'b1;
        repeat (3) @(negedge clock);
        sw = 4'd5;
        repeat (4) @(negedge clock);
        enter = 1'b0;
        settle(6);
        chk("s4_one_pulse", pulses, p0 + 1);
        chk("s4_value", last_h, 4'd6);
        chk("s4_occupied", occupied, 9'h020);

        // Scenario 5: game over blocks moves until new_game.
        @(negedge clock); win = 1'b1;
        @(negedge clock); win = 1'b0;
        e0 = errs;
        press(4'd3, 4);
        chk("s5_won_err", errs, e0 + 1);
        chk("s5_won_occ", occupied, 9'h020);
        pulse_new_game();
        chk("s5_new_game", occupied, 9'd0);
        press(4'd3, 4);
        chk("s5_move3", last_h, 4'd3);
        chk("s5_occupied", occupied, 9'h004);

        // Full board: every press rejected.
        for (int v = 1; v <= 9; v++) begin
            @(negedge clock); cMove = 4'(v);
        end
        @(negedge clock); cMove = 4'hF;
        settle(1);
        chk("full_occ", occupied, 9'h1FF);
        e0 = errs;
        press(4'd5, 3);
        chk("full_err", errs, e0 + 1);
        pulse_new_game();

        // Scenario 6: reset during the issue cycle, Enter held through release.
        @(negedge clock); sw = 4'd4; enter = 1'b1;
        @(posedge clock); @(posedge clock); @(posedge clock);
        #2 reset = 1'b0;
        #1;
        chk("s6_async_hMove", hMove, 4'hF);
        chk("s6_async_occ", occupied, 9'd0);
        chk("s6_async_pulse", move_pulse, 1'b0);
        @(negedge clock); reset = 1'b1;
        p0 = pulses;
        settle(10);
        chk("s6_held_nopulse", pulses, p0);
        enter = 1'b0;
        settle(4);
        press(4'd4, 3);
        chk("s6_repress", pulses, p0 + 1);
        chk("s6_value", last_h, 4'd4);

        // Randomized traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clock);
            if ($urandom_range(0, 5) == 0) enter = ~enter;
            sw       = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                                    : 4'($urandom_range(1, 9));
            cMove    = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 9)) : 4'hF;
            win      = ($urandom_range(0, 80) == 0);
            new_game = ($urandom_range(0, 40) == 0);
            reset    = ($urandom_range(0, 400) != 0);
        end
        @(negedge clock);
        reset = 1'b1; enter = 1'b0; win = 1'b0; new_game = 1'b0; cMove = 4'hF;
        settle(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
